// File: rtl/key_debounce_array_pkg.sv
// Shared types and helpers for the key_debounce_array block.
//   key_state_e  : per-channel press-tracking FSM state
//   hcnt_width() : width of the hold/repeat counter
package key_pkg;

  typedef enum logic [1:0] {
    KEY_REL  = 2'd0,  // key not pressed
    KEY_PRS  = 2'd1,  // pressed, counting towards key_hold
    KEY_HELD = 2'd2   // long press, emitting key_repeat
  } key_state_e;

  // Counter must reach max(hold, repeat) - 1; never narrower than 1 bit.
  function automatic int hcnt_width(input int hold_cycles, input int repeat_cycles);
    int m;
    m = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce_array_if.sv
// Bundle of key pins and conditioned key events.
//   button        : raw asynchronous key pins (driven by master)
//   key_level     : debounced pressed state, 1 = pressed
//   key_press     : 1-cycle pulse on debounced press
//   key_release   : 1-cycle pulse on debounced release
//   key_hold      : 1-cycle pulse once per press after the hold time
//   key_repeat    : 1-cycle pulse every repeat period after key_hold
//   key_state_dbg : 2 bits per channel, FSM state (key_state_e encoding)
//
// Event handshake: there is no valid/ready pair. Every event output is a
// single-cycle pulse that the consumer must sample on the clock edge after
// it is raised; the block never stalls and never holds an event waiting
// for acceptance.
interface key_debounce_array_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0]   button;
  logic [NUM_KEYS-1:0]   key_level;
  logic [NUM_KEYS-1:0]   key_press;
  logic [NUM_KEYS-1:0]   key_release;
  logic [NUM_KEYS-1:0]   key_hold;
  logic [NUM_KEYS-1:0]   key_repeat;
  logic [2*NUM_KEYS-1:0] key_state_dbg;

  modport master (
    output button,
    input  key_level, key_press, key_release, key_hold, key_repeat, key_state_dbg
  );

  modport slave (
    input  button,
    output key_level, key_press, key_release, key_hold, key_repeat, key_state_dbg
  );
endinterface

// File: rtl/key_debounce_array_channel.sv
// One key channel: two-flop synchroniser, debounce counter, and the
// press/hold/repeat FSM with its hold counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   button      : raw pin
//   key_level   : debounced pressed state
//   key_press   : pulse on debounced 0->1
//   key_release : pulse on debounced 1->0
//   key_hold    : pulse HOLD_CYCLES after key_press
//   key_repeat  : pulse every REPEAT_CYCLES after key_hold (if REPEAT_EN)
//   state_dbg   : current FSM state
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned CNT_W         = 3,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250,
  parameter int unsigned REPEAT_EN     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  output logic       key_level,
  output logic       key_press,
  output logic       key_release,
  output logic       key_hold,
  output logic       key_repeat,
  output key_state_e state_dbg
);

  localparam int              HW          = hcnt_width(int'(HOLD_CYCLES), int'(REPEAT_CYCLES));
  localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(2**CNT_W - 1);
  localparam logic [HW-1:0]   HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]   REPEAT_LAST = HW'(REPEAT_CYCLES - 1);

  logic             sync0_q, sync0_d;
  logic             sync1_q, sync1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             hold_q, hold_d;
  logic             repeat_q, repeat_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  key_state_e       state_q, state_d;

  logic deb_idle;
  logic deb_done;

  always_comb begin
    // Polarity is folded into the first sync stage so everything after it
    // sees 1 = pressed.
    sync0_d = (ACTIVE_LOW != 0) ? ~button : button;
    sync1_d = sync0_q;

    // The counter only advances while the synchronised pin disagrees with
    // the debounced level; any agreement (a glitch ending) clears it.
    deb_idle  = (level_q == sync1_q);
    deb_done  = !deb_idle && (cnt_q == DEB_MAX);
    cnt_d     = (deb_idle || deb_done) ? '0 : cnt_q + CNT_W'(1);
    level_d   = deb_done ? ~level_q : level_q;
    press_d   = deb_done && !level_q;
    release_d = deb_done && level_q;

    // The FSM reacts to the same-cycle press/release decision so that
    // key_hold lands exactly HOLD_CYCLES edges after key_press.
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    hold_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      KEY_REL: begin
        if (press_d) begin
          state_d = KEY_PRS;
          hcnt_d  = '0;
        end
      end
      KEY_PRS: begin
        // Release takes priority over a coincident terminal count.
        if (release_d) begin
          state_d = KEY_REL;
          hcnt_d  = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          hold_d  = 1'b1;
          hcnt_d  = '0;
          state_d = KEY_HELD;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      KEY_HELD: begin
        if (release_d) begin
          state_d = KEY_REL;
          hcnt_d  = '0;
        end else if (hcnt_q == REPEAT_LAST) begin
          repeat_d = (REPEAT_EN != 0);
          hcnt_d   = '0;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: begin
        state_d = KEY_REL;
        hcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      repeat_q  <= 1'b0;
      hcnt_q    <= '0;
      state_q   <= KEY_REL;
    end else begin
      sync0_q   <= sync0_d;
      sync1_q   <= sync1_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      repeat_q  <= repeat_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_hold    = hold_q;
  assign key_repeat  = repeat_q;
  assign state_dbg   = state_q;

endmodule

// File: rtl/key_debounce_array.sv
// N-channel push-button conditioner. Each channel is an independent
// key_debounce_channel; all share clk and rst_n.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : key_debounce_array_if.slave (pins in, events/debug out)
module key_debounce_array
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS      = 4,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned CNT_W         = 3,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250,
  parameter int unsigned REPEAT_EN     = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  key_debounce_array_if.slave  bus
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic       lvl;
    logic       prs;
    logic       rel;
    logic       hld;
    logic       rpt;
    key_state_e st;

    key_debounce_channel #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .CNT_W         (CNT_W),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .REPEAT_EN     (REPEAT_EN)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .button      (bus.button[i]),
      .key_level   (lvl),
      .key_press   (prs),
      .key_release (rel),
      .key_hold    (hld),
      .key_repeat  (rpt),
      .state_dbg   (st)
    );

    assign bus.key_level[i]            = lvl;
    assign bus.key_press[i]            = prs;
    assign bus.key_release[i]          = rel;
    assign bus.key_hold[i]             = hld;
    assign bus.key_repeat[i]           = rpt;
    assign bus.key_state_dbg[2*i +: 2] = st;
  end

endmodule

// File: doc/key_debounce_array.md
Name: key_debounce_array

Overview:
- Parametrised N-channel push-button conditioner: synchroniser, per-channel debounce filter, and press/release/hold/auto-repeat event generator.
- Sits between raw board key pins and control logic (timer set/start/stop keys).
- Replaces single-key, level-only debouncing with edge events and long-press handling.
- All channels are identical and independent, sharing one clock.

Parameters:
- NUM_KEYS, 4: number of independent key channels (>=1).
- ACTIVE_LOW, 1: 1 = pin reads 0 when pressed (input inverted in the first sync stage); 0 = active-high pin.
- CNT_W, 3: debounce counter width; required stability window = 2**CNT_W clocks.
- HOLD_CYCLES, 1000: clocks of debounced press before key_hold pulses (>=2).
- REPEAT_CYCLES, 250: clocks between key_repeat pulses once held (>=2).
- REPEAT_EN, 1: 0 disables key_repeat (key_hold still fires).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset (assert async, release sync to clk externally).
- button  in  NUM_KEYS  raw asynchronous key pins.
- key_level  out  NUM_KEYS  debounced pressed state, 1 = pressed.
- key_press  out  NUM_KEYS  1-cycle pulse on debounced 0->1.
- key_release  out  NUM_KEYS  1-cycle pulse on debounced 1->0.
- key_hold  out  NUM_KEYS  1-cycle pulse, once per press, after HOLD_CYCLES.
- key_repeat  out  NUM_KEYS  1-cycle pulse every REPEAT_CYCLES after key_hold while still pressed.

Behaviour:
- Reset: all outputs 0; sync flops 0 (not-pressed); debounce and hold counters 0; FSM in REL.
- Sync: sync0 <= ACTIVE_LOW ? ~button : button; sync1 <= sync0. Two-flop per channel; no logic between stages.
- Debounce: idle = (key_level == sync1). If idle, cnt <= 0; else cnt <= cnt+1.
  - When not idle and cnt == 2**CNT_W-1, key_level toggles and cnt wraps to 0.
  - key_level therefore changes on the 2**CNT_W-th consecutive edge where sync1 != key_level.
  - Pin-to-key_level latency = 2**CNT_W + 2 edges.
  - Any glitch returning sync1 to key_level before then clears cnt with no output change.
- key_press/key_release: asserted in the same cycle key_level changes (registered, not derived from key_level delay); never both high.
- Per-channel FSM:
  - REL: wait for debounced press -> PRS; hcnt <= 0.
  - PRS: hcnt increments each cycle.
    - hcnt == HOLD_CYCLES-1: key_hold = 1, hcnt <= 0, go to HELD.
    - Debounced release -> REL.
  - HELD: hcnt increments.
    - hcnt == REPEAT_CYCLES-1: key_repeat = REPEAT_EN, hcnt <= 0.
    - Debounced release -> REL.
- Release wins: release in the same cycle hcnt reaches its terminal count yields key_release only; no hold/repeat.
- Hold timing: first key_hold is HOLD_CYCLES edges after the key_press edge. key_repeat follows at +REPEAT_CYCLES, +2*REPEAT_CYCLES, and so on.
- hcnt width: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)); no wrap beyond terminal count.
- Channels are fully independent; simultaneous events on multiple channels assert multiple bits in the same cycle.
- Reset mid-operation: all state cleared immediately (async). A key physically held through reset release is re-detected as a fresh press after 2**CNT_W + 2 edges.

Decomposition:
- Package key_pkg: key_state_e enum {KEY_REL, KEY_PRS, KEY_HELD} (2-bit); function for hcnt width; localparam DEB_MAX = 2**CNT_W-1 computed in-module from CNT_W.
- Sub-module key_debounce_channel: one key (sync, debounce counter, FSM, hold counter), all scalar ports. Top is a generate loop over NUM_KEYS.

Test Plan:
1. Reset/idle: rst_n=0 for 3 clocks, button=all 1 (ACTIVE_LOW) -> all outputs 0; after release, outputs stay 0 for 100 clocks.
2. Clean press, CNT_W=3: button[0] 1->0 held -> key_level[0] and key_press[0] rise 10 edges later. key_press high exactly 1 cycle; other channels unchanged.
3. Bounce rejection: button[1] toggles low for 5 clocks, high 2, low 6, high -> no key_level/key_press. Then a stable low produces key_press exactly 10 edges after the final transition.
4. Long press, HOLD_CYCLES=20, REPEAT_CYCLES=8: hold key 60 clocks -> key_hold 20 edges after key_press; key_repeat at +28, +36, +44, +52. On release, key_release fires and no further repeats.
5. Release at terminal count: release timed so debounced release coincides with hcnt=HOLD_CYCLES-1 -> key_release only, key_hold stays 0. Also check REPEAT_EN=0 -> key_hold fires, key_repeat never asserts.
6. Async reset mid-hold: assert rst_n in HELD between clock edges -> outputs 0 immediately. Key still held at release -> key_press 10 edges after rst_n high, no key_release pulse.
